alu_serial_ctrl: RTL and testbench

- Producer end of the 4-bit ALU function-code interface.
- Accepts an ALU request (ALUOp, funct, two operands) over a valid/ready handshake and decodes it to the 4-bit function code F.
- Drives an external 1-bit ALU slice LSB-first for WIDTH cycles, threading carry between bits; assembles the result word and returns it with zero/error flags over a second valid/ready handshake.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_ctrl_decode.sv | 39 +++
 rtl/alu_serial_ctrl.sv | 155 +++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU controller: 4-bit function codes,
// ALUOp encodings, R-type funct encodings and the controller state enum.
package alu_pkg;

   // Function codes presented to the 1-bit ALU slice
   localparam logic [3:0] F_AND = 4'b0000;
   localparam logic [3:0] F_OR  = 4'b0001;
   localparam logic [3:0] F_ADD = 4'b0010;
   localparam logic [3:0] F_SUB = 4'b0110;
   localparam logic [3:0] F_SLT = 4'b0111;
   localparam logic [3:0] F_NOR = 4'b1100;

   // ALUOp encodings
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_RSVD  = 2'b11;

   // R-type funct encodings
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_NOR = 6'b100111;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of (aluop, funct) into the 4-bit ALU function code.
// Optional feature macro: ALU_NOR_EN makes aluop=10/funct=100111 a legal nor;
// without it that encoding is illegal. Illegal encodings return f=0.
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [3:0] f,
   output logic       illegal
);

   // Table lookup; anything not listed is flagged illegal
   always_comb begin
      f       = F_AND;
      illegal = 1'b0;
      case (aluop)
         ALUOP_ADD: f = F_ADD;
         ALUOP_SUB: f = F_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FUNCT_ADD: f = F_ADD;
               FUNCT_SUB: f = F_SUB;
               FUNCT_AND: f = F_AND;
               FUNCT_OR:  f = F_OR;
               FUNCT_SLT: f = F_SLT;
`ifdef ALU_NOR_EN
               FUNCT_NOR: f = F_NOR;
`else
               FUNCT_NOR: illegal = 1'b1;
`endif
               default:   illegal = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Serial ALU controller: accepts a request, decodes it, walks an external
// 1-bit ALU slice LSB-first for WIDTH cycles threading the carry, and returns
// the assembled result with zero/err flags.
// Optional feature macro: ALU_NOR_EN (nor support, handled in alu_ctrl_decode).
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// The request side (in_valid/in_ready) must hold its payload until accepted;
// in_ready is high only in IDLE. The result side (out_valid/out_ready) holds
// result/zero/err stable while out_valid is high until out_ready is seen.
// in_ready and out_valid are never high in the same cycle.
module alu_serial_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       aluop,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             slice_en,
   output logic [3:0]       slice_f,
   output logic             slice_a,
   output logic             slice_b,
   output logic             slice_cin,
   input  logic             slice_y,
   input  logic             slice_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             err
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] res_n;
   logic [3:0]       f_q;
   logic             err_q;
   logic             carry;
   logic [IDX_W-1:0] idx;
   logic [3:0]       dec_f;
   logic             dec_illegal;
   logic             accept;
   logic             last;
   logic             less;

   alu_ctrl_decode u_decode (
      .aluop   (aluop),
      .funct   (funct),
      .f       (dec_f),
      .illegal (dec_illegal)
   );

   assign accept = in_valid && in_ready;
   assign last   = (idx == IDX_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_n;
   end

   // Next-state logic; illegal requests skip RUN entirely
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: if (accept) state_n = dec_illegal ? ST_DONE : ST_RUN;
         ST_RUN:  if (last)   state_n = ST_DONE;
         ST_DONE: if (out_ready) state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Outputs decoded from state; slice pins are quiet outside RUN
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      slice_en  = 1'b0;
      slice_f   = 4'b0000;
      slice_a   = 1'b0;
      slice_b   = 1'b0;
      slice_cin = 1'b0;
      case (state)
         ST_IDLE: in_ready = 1'b1;
         ST_RUN: begin
            slice_en  = 1'b1;
            slice_f   = f_q;
            slice_a   = a_q[idx];
            slice_b   = b_q[idx];
            slice_cin = carry;
         end
         ST_DONE: out_valid = 1'b1;
         default: ;
      endcase
   end

   // Next result word: insert the current bit; at the MSB of slt replace the
   // whole word with the overflow-corrected sign of a-b
   always_comb begin
      less     = slice_y ^ (carry ^ slice_cout);
      res_n    = res_q;
      res_n[idx] = slice_y;
      if (f_q == F_SLT && last) res_n = {{(WIDTH-1){1'b0}}, less};
   end

   // Operand latch, bit counter, carry chain and result assembly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         f_q   <= 4'b0000;
         idx   <= '0;
         carry <= 1'b0;
         res_q <= '0;
         err_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  a_q   <= opa;
                  b_q   <= opb;
                  f_q   <= dec_f;
                  idx   <= '0;
                  carry <= dec_f[2];
                  res_q <= '0;
                  err_q <= dec_illegal;
               end
            end
            ST_RUN: begin
               res_q <= res_n;
               carry <= slice_cout;
               idx   <= last ? '0 : idx + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign result = res_q;
   assign err    = err_q;
   // Zero only describes a presented, legal result
   assign zero   = (state == ST_DONE) && !err_q && (res_q == '0);

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl at WIDTH=8 with a behavioural 1-bit slice.
module tb_alu_serial_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   aluop;
   logic [5:0]   funct;
   logic [W-1:0] opa;
   logic [W-1:0] opb;
   logic         slice_en;
   logic [3:0]   slice_f;
   logic         slice_a;
   logic         slice_b;
   logic         slice_cin;
   logic         slice_y;
   logic         slice_cout;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         zero;
   logic         err;

   int n_checks;
   int n_fail;

   alu_serial_ctrl #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .aluop      (aluop),
      .funct      (funct),
      .opa        (opa),
      .opb        (opb),
      .slice_en   (slice_en),
      .slice_f    (slice_f),
      .slice_a    (slice_a),
      .slice_b    (slice_b),
      .slice_cin  (slice_cin),
      .slice_y    (slice_y),
      .slice_cout (slice_cout),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .zero       (zero),
      .err        (err)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural 1-bit ALU slice
   logic bb;
   always_comb begin
      bb = slice_b ^ slice_f[2];
      case (slice_f)
         4'b0000: slice_y = slice_a & slice_b;
         4'b0001: slice_y = slice_a | slice_b;
         4'b1100: slice_y = ~(slice_a | slice_b);
         default: slice_y = slice_a ^ bb ^ slice_cin;
      endcase
      slice_cout = (slice_a & bb) | (slice_a & slice_cin) | (bb & slice_cin);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request and follow it to the result handshake
   task automatic run_op(input string tag, input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_res, input logic exp_zero,
                         input logic exp_err, input int exp_lat,
                         input logic [3:0] exp_f, input int hold);
      int cyc;
      int en_cnt;
      logic f_ok;
      logic first_cin;
      logic busy_ok;
      logic stable_ok;
      check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
      aluop    = op;
      funct    = fn;
      opa      = a;
      opb      = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      opa      = '0;
      opb      = '0;
      cyc       = 1;
      en_cnt    = 0;
      f_ok      = 1'b1;
      first_cin = 1'b0;
      busy_ok   = 1'b1;
      while (!out_valid && cyc < 40) begin
         if (in_ready) busy_ok = 1'b0;
         if (slice_en) begin
            if (en_cnt == 0) first_cin = slice_cin;
            if (slice_f !== exp_f) f_ok = 1'b0;
            en_cnt++;
         end
         tick();
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
      check({tag, "_en_cycles"}, 32'(en_cnt), (exp_lat > 1) ? 32'(W) : 32'd0);
      check({tag, "_busy_in_ready"}, 32'(busy_ok), 32'd1);
      if (en_cnt > 0) begin
         check({tag, "_slice_f"}, 32'(f_ok), 32'd1);
         check({tag, "_first_cin"}, 32'(first_cin), 32'(exp_f[2]));
      end
      check({tag, "_result"}, 32'(result), 32'(exp_res));
      check({tag, "_zero"}, 32'(zero), 32'(exp_zero));
      check({tag, "_err"}, 32'(err), 32'(exp_err));
      if (hold > 0) begin
         stable_ok = 1'b1;
         for (int i = 0; i < hold; i++) begin
            tick();
            if (!out_valid || in_ready || result !== exp_res ||
                zero !== exp_zero || err !== exp_err) stable_ok = 1'b0;
         end
         check({tag, "_held_stable"}, 32'(stable_ok), 32'd1);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_back_idle"}, 32'({in_ready, out_valid}), 32'b10);
   endtask

   initial begin
      int cyc;
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      aluop     = 2'b00;
      funct     = 6'b000000;
      opa       = '0;
      opb       = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // Reset state
      check("rst_result", 32'(result), 32'd0);
      check("rst_flags", 32'({zero, err, out_valid, slice_en}), 32'd0);
      check("rst_slice", 32'({slice_f, slice_a, slice_b, slice_cin}), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      //      tag        aluop  funct       a      b      res    z     e     lat f        hold
      run_op("add",     2'b00, 6'b000000, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 9, 4'b0010, 0);
      run_op("sub_zero",2'b01, 6'b111111, 8'h07, 8'h07, 8'h00, 1'b1, 1'b0, 9, 4'b0110, 0);
      run_op("slt_ovf", 2'b10, 6'b101010, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 9, 4'b0111, 0);
      run_op("slt_no",  2'b10, 6'b101010, 8'h02, 8'hFD, 8'h00, 1'b1, 1'b0, 9, 4'b0111, 0);
      run_op("rtype_add_wrap", 2'b10, 6'b100000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 9, 4'b0010, 0);
      run_op("or",      2'b10, 6'b100101, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0, 9, 4'b0001, 0);
      run_op("illegal", 2'b10, 6'b000000, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1, 4'b0000, 0);
      run_op("rsvd_op", 2'b11, 6'b100000, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1, 4'b0000, 0);
`ifdef ALU_NOR_EN
      run_op("nor",     2'b10, 6'b100111, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 9, 4'b1100, 0);
`else
      run_op("nor_off", 2'b10, 6'b100111, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1, 4'b0000, 0);
`endif
      run_op("and_bp",  2'b10, 6'b100100, 8'hAA, 8'h0F, 8'h0A, 1'b0, 1'b0, 9, 4'b0000, 5);

      // Reset in the middle of RUN, at bit index 3
      aluop    = 2'b00;
      opa      = 8'h3C;
      opb      = 8'h05;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cyc = 1;
      while (!(slice_en && dut.idx == 3) && cyc < 20) begin
         tick();
         cyc++;
      end
      check("midrun_reach_idx3", 32'(cyc), 32'd4);
      rst_n = 1'b0;
      #1;
      check("midrun_rst_quiet", 32'({slice_en, out_valid}), 32'd0);
      check("midrun_rst_result", 32'(result), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("midrun_rst_ready", 32'(in_ready), 32'd1);
      repeat (3) tick();
      check("midrun_no_result", 32'(out_valid), 32'd0);
      run_op("after_rst", 2'b00, 6'b000000, 8'h10, 8'h22, 8'h32, 1'b0, 1'b0, 9, 4'b0010, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
